// File: rtl/avs_i2c_pkg.sv
// avs_i2c_pkg: opcodes, register map, status/interrupt bit positions and sequencer states
package avs_i2c_pkg;
    localparam logic [2:0] OP_START     = 3'd1;
    localparam logic [2:0] OP_STOP      = 3'd2;
    localparam logic [2:0] OP_WRITE     = 3'd3;
    localparam logic [2:0] OP_READ_ACK  = 3'd4;
    localparam logic [2:0] OP_READ_NACK = 3'd5;

    localparam logic [2:0] REG_RXDATA   = 3'd0;
    localparam logic [2:0] REG_CMD      = 3'd1;
    localparam logic [2:0] REG_CLK_DIV  = 3'd2;
    localparam logic [2:0] REG_CONTROL  = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_INT_PEND = 3'd5;
    localparam logic [2:0] REG_INT_EN   = 3'd6;

    localparam int ST_BUSY     = 0;
    localparam int ST_ACK_FAIL = 1;
    localparam int ST_IRQ      = 2;
    localparam int ST_CMD_FULL = 3;
    localparam int ST_RX_EMPTY = 4;
    localparam int ST_CMD_OVF  = 5;
    localparam int ST_ABORT    = 24;

    localparam int INT_DONE = 0;
    localparam int INT_NACK = 1;
    localparam int INT_RX   = 2;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} seq_state_t;

    function automatic logic op_valid(input logic [2:0] op);
        return op >= OP_START && op <= OP_READ_NACK;
    endfunction

    function automatic logic op_is_read(input logic [2:0] op);
        return op == OP_READ_ACK || op == OP_READ_NACK;
    endfunction
endpackage

// File: rtl/i2c_sync_fifo.sv
// i2c_sync_fifo: single-clock FIFO with flush and occupancy level
module i2c_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;

    // full is taken before any same-cycle pop, so a push into a full FIFO is always lost
    assign full = level == FULL_LEVEL;
    assign empty = level == '0;
    assign do_push = push && !full;
    assign do_pop = pop && !empty;
    assign dout = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/avs_i2c_fifo_ctrl.sv
// avs_i2c_fifo_ctrl: Avalon-MM command/receive FIFO front end sequencing an i2c_core
module avs_i2c_fifo_ctrl
    import avs_i2c_pkg::*;
#(
    parameter int          CMD_DEPTH   = 8,
    parameter int          RX_DEPTH    = 8,
    parameter logic [15:0] CLK_DIV_RST = 16'd250
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [2:0]  avs_s0_address,
    input  logic        avs_s0_read,
    output logic [31:0] avs_s0_readdata,
    input  logic        avs_s0_write,
    input  logic [31:0] avs_s0_writedata,
    output logic        avs_s0_irq,
    output logic [15:0] clk_div,
    output logic        core_start,
    output logic        core_stop,
    output logic        core_write,
    output logic        core_read_ack,
    output logic        core_read_nack,
    output logic [7:0]  core_txdata,
    input  logic [7:0]  core_rxdata,
    input  logic        core_busy,
    input  logic        core_ack_fail,
    input  logic        core_rx_done,
    input  logic        core_tx_done,
    input  logic        core_start_done,
    input  logic        core_stop_done
);
    localparam int CW = $clog2(CMD_DEPTH) + 1;
    localparam int RW = $clog2(RX_DEPTH) + 1;

    seq_state_t state, state_nx;
    logic [10:0] cmd_head;
    logic [CW-1:0] cmd_level;
    logic [7:0] rx_head;
    logic [RW-1:0] rx_level;
    logic cmd_full, cmd_empty, cmd_flush, rx_full, rx_empty, rx_push;
    logic [2:0] cur_op, int_pend, int_en, int_set, int_clr;
    logic ack_fail, cmd_overflow, abort_on_nack, discard;
    logic wr_cmd, wr_ctrl, ctrl_clr, ctrl_flush, go, done, nack;
    logic [31:0] status;
    logic unused_wdata;

    assign unused_wdata = &{1'b0, avs_s0_writedata[31:11]};
    assign wr_cmd = avs_s0_write && avs_s0_address == REG_CMD && op_valid(avs_s0_writedata[10:8]);
    assign wr_ctrl = avs_s0_write && avs_s0_address == REG_CONTROL;
    assign ctrl_clr = wr_ctrl && avs_s0_writedata[0];
    assign ctrl_flush = wr_ctrl && avs_s0_writedata[1];
    assign go = state == S_IDLE && !cmd_empty && !core_busy && !ctrl_flush && !(op_is_read(cmd_head[10:8]) && rx_full);
    assign done = state == S_WAIT && (cur_op == OP_START ? core_start_done : cur_op == OP_STOP ? core_stop_done : cur_op == OP_WRITE ? core_tx_done : core_rx_done);
    assign nack = done && cur_op == OP_WRITE && core_ack_fail;
    assign cmd_flush = ctrl_flush || (nack && abort_on_nack);
    // a flush seen while a read is in flight must not let its byte land in the emptied RX FIFO
    assign rx_push = done && op_is_read(cur_op) && !discard;
    assign int_set = {rx_level >= RW'(RX_DEPTH / 2), nack, done && cmd_empty};
    assign int_clr = avs_s0_write && avs_s0_address == REG_INT_PEND ? avs_s0_writedata[2:0] : 3'd0;

    i2c_sync_fifo #(.WIDTH(11), .DEPTH(CMD_DEPTH)) u_cmd_fifo (
        .clk(clk), .reset(reset), .push(wr_cmd), .pop(state == S_ISSUE), .flush(cmd_flush),
        .din(avs_s0_writedata[10:0]), .dout(cmd_head), .full(cmd_full), .empty(cmd_empty), .level(cmd_level)
    );

    i2c_sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk(clk), .reset(reset), .push(rx_push), .pop(avs_s0_read && avs_s0_address == REG_RXDATA), .flush(ctrl_flush),
        .din(core_rxdata), .dout(rx_head), .full(rx_full), .empty(rx_empty), .level(rx_level)
    );

    always_comb begin
        state_nx = state;
        {core_start, core_stop, core_write, core_read_ack, core_read_nack} = 5'd0;
        if (go) state_nx = S_ISSUE;
        if (state == S_ISSUE) begin
            state_nx = S_WAIT;
            core_start = cur_op == OP_START;
            core_stop = cur_op == OP_STOP;
            core_write = cur_op == OP_WRITE;
            core_read_ack = cur_op == OP_READ_ACK;
            core_read_nack = cur_op == OP_READ_NACK;
        end
        if (done) state_nx = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
            cur_op <= 3'd0;
            core_txdata <= 8'd0;
            clk_div <= CLK_DIV_RST;
            int_pend <= 3'd0;
            int_en <= 3'd0;
            ack_fail <= 1'b0;
            cmd_overflow <= 1'b0;
            abort_on_nack <= 1'b1;
            discard <= 1'b0;
            avs_s0_irq <= 1'b0;
        end else begin
            state <= state_nx;
            if (go) {cur_op, core_txdata} <= cmd_head;
            if (avs_s0_write && avs_s0_address == REG_CLK_DIV) clk_div <= avs_s0_writedata[15:0];
            if (avs_s0_write && avs_s0_address == REG_INT_EN) int_en <= avs_s0_writedata[2:0];
            if (wr_ctrl) abort_on_nack <= avs_s0_writedata[2];
            ack_fail <= nack || (ack_fail && !ctrl_clr);
            cmd_overflow <= (wr_cmd && cmd_full) || (cmd_overflow && !ctrl_clr);
            int_pend <= (int_pend & ~int_clr) | int_set;
            discard <= state_nx != S_IDLE && (discard || ctrl_flush);
            avs_s0_irq <= |(int_pend & int_en);
        end
    end

    assign status = {7'd0, abort_on_nack, 8'(rx_level), 8'(cmd_level), 2'd0, cmd_overflow, rx_empty,
                     cmd_full, avs_s0_irq, ack_fail, state != S_IDLE || !cmd_empty};

    assign avs_s0_readdata = avs_s0_address == REG_RXDATA ? {23'd0, rx_empty, rx_empty ? 8'd0 : rx_head} :
                             avs_s0_address == REG_CLK_DIV ? {16'd0, clk_div} :
                             avs_s0_address == REG_STATUS ? status :
                             avs_s0_address == REG_INT_PEND ? {29'd0, int_pend} :
                             avs_s0_address == REG_INT_EN ? {29'd0, int_en} : 32'd0;
endmodule
